// File: rtl/sprite_blitter_if.sv
// Bus bundle for sprite_blitter: draw request, sprite-memory read port and framebuffer pixel port.
interface sprite_blitter_if #(
    parameter int XW = 6,
    parameter int YW = 5
);
    logic          start;
    logic [7:0]    spr_x;
    logic [7:0]    spr_y;
    logic [11:0]   spr_addr;
    logic [3:0]    spr_n;
    logic          wide16;
    logic          clip_en;
    logic [11:0]   rd_memory_address;
    logic [7:0]    rd_memory_data;
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic          fb_rd_px;
    logic          fb_we;
    logic          fb_wr_px;
    logic          busy;
    logic          done;
    logic          collision;

    // master is the blitter; slave is the host together with sprite memory and framebuffer
    modport master (
        input  start, spr_x, spr_y, spr_addr, spr_n, wide16, clip_en,
        input  rd_memory_data, fb_rd_px,
        output rd_memory_address, fb_x, fb_y, fb_we, fb_wr_px, busy, done, collision
    );

    modport slave (
        output start, spr_x, spr_y, spr_addr, spr_n, wide16, clip_en,
        output rd_memory_data, fb_rd_px,
        input  rd_memory_address, fb_x, fb_y, fb_we, fb_wr_px, busy, done, collision
    );
endinterface

// File: rtl/sprite_blitter.sv
// XOR sprite blitter: fetches up to 16 rows of sprite bytes, then read-modify-writes each set pixel
// into a 1-bpp framebuffer with optional edge clipping and collision detection.
module sprite_blitter #(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32,
    parameter int XW       = $clog2(SCREEN_W),
    parameter int YW       = $clog2(SCREEN_H)
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    sprite_blitter_if.master bus
);
    localparam logic [8:0] SW9 = 9'(SCREEN_W);
    localparam logic [8:0] SH9 = 9'(SCREEN_H);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PIX_RD, PIX_WR, FINISH} state_e;
    state_e state_q, state_d;

    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic          clip_q, clip_d;
    logic          w16_q, w16_d;
    logic [4:0]    nrows_q, nrows_d;
    logic [5:0]    nbytes_q, nbytes_d;
    logic [11:0]   addr_q, addr_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [4:0]    idx_q, idx_d;
    logic [3:0]    cur_r_q, cur_r_d;
    logic [3:0]    cur_c_q, cur_c_d;
    logic [XW-1:0] fbx_q, fbx_d;
    logic [YW-1:0] fby_q, fby_d;
    logic          coll_q, coll_d;
    logic [15:0]   buf_q [16];
    logic [15:0]   buf_d [16];

    logic          accept;
    logic          big;
    logic [15:0]   colmask;
    logic [15:0]   row_ok;
    logic          hit;
    logic [3:0]    hit_r;
    logic [3:0]    hit_c;
    logic [15:0]   hit_row;

    assign accept = (state_q == IDLE) && bus.start;
    assign big    = bus.wide16 && (bus.spr_n == 4'd0);

    // State register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (bus.start) state_d = (!bus.wide16 && bus.spr_n == 4'd0) ? FINISH : FETCH;
            FETCH:        if (cnt_q == nbytes_q - 6'd1) state_d = LOAD;
            LOAD, PIX_WR: state_d = hit ? PIX_RD : FINISH;
            PIX_RD:       state_d = PIX_WR;
            FINISH:       state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == FINISH);
        bus.fb_we    = (state_q == PIX_WR);
        bus.fb_wr_px = (state_q == PIX_WR) && !bus.fb_rd_px;
    end

    assign bus.rd_memory_address = addr_q;
    assign bus.fb_x              = fbx_q;
    assign bus.fb_y              = fby_q;
    assign bus.collision         = coll_q;

    // Draw parameters captured at acceptance; origin reduced modulo the screen size here
    always_comb begin
        ox_d     = ox_q;
        oy_d     = oy_q;
        clip_d   = clip_q;
        w16_d    = w16_q;
        nrows_d  = nrows_q;
        nbytes_d = nbytes_q;
        if (accept) begin
            ox_d     = XW'(bus.spr_x);
            oy_d     = YW'(bus.spr_y);
            clip_d   = bus.clip_en;
            w16_d    = big;
            nrows_d  = big ? 5'd16 : {1'b0, bus.spr_n};
            nbytes_d = big ? 6'd32 : {2'b00, bus.spr_n};
        end
    end

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        idx_d   = idx_q;
        cur_r_d = cur_r_q;
        cur_c_d = cur_c_q;
        fbx_d   = fbx_q;
        fby_d   = fby_q;
        coll_d  = coll_q;
        case (state_q)
            IDLE: if (bus.start) begin
                addr_d = bus.spr_addr;
                cnt_d  = '0;
                coll_d = 1'b0;
            end
            FETCH: begin
                addr_d = addr_q + 12'd1;
                cnt_d  = cnt_q + 6'd1;
                pend_d = 1'b1;
                idx_d  = cnt_q[4:0];
            end
            LOAD, PIX_WR: if (hit) begin
                cur_r_d = hit_r;
                cur_c_d = hit_c;
                fbx_d   = XW'(9'(ox_q) + 9'(hit_c));
                fby_d   = YW'(9'(oy_q) + 9'(hit_r));
            end
            default: ;
        endcase
        if (state_q == PIX_WR && bus.fb_rd_px) coll_d = 1'b1;
    end

    // Byte landing from memory one cycle after its address; visited bits are erased so the
    // search below always lands on the next pending pixel without spending idle cycles.
    always_comb begin
        buf_d = buf_q;
        if (pend_q) begin
            if (w16_q) begin
                if (idx_q[0]) buf_d[idx_q[4:1]][7:0]  = bus.rd_memory_data;
                else          buf_d[idx_q[4:1]][15:8] = bus.rd_memory_data;
            end else begin
                buf_d[idx_q[3:0]][15:8] = bus.rd_memory_data;
            end
        end
        if (state_q == PIX_WR) buf_d[cur_r_q][4'd15 - cur_c_q] = 1'b0;
    end

    always_comb begin
        colmask = '0;
        row_ok  = '0;
        for (int i = 0; i < 16; i++) begin
            if ((w16_q || i < 8) && (!clip_q || (9'(ox_q) + 9'(i)) < SW9)) colmask[15-i] = 1'b1;
            if ((5'(i) < nrows_q) && (!clip_q || (9'(oy_q) + 9'(i)) < SH9)) row_ok[i] = 1'b1;
        end
    end

    always_comb begin
        hit   = 1'b0;
        hit_r = '0;
        for (int r = 15; r >= 0; r--) begin
            if (row_ok[r] && |(buf_d[r] & colmask)) begin
                hit   = 1'b1;
                hit_r = 4'(r);
            end
        end
        hit_row = buf_d[hit_r] & colmask;
        hit_c   = '0;
        for (int c = 15; c >= 0; c--) begin
            if (hit_row[15-c]) hit_c = 4'(c);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            fbx_q  <= '0;
            fby_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            fbx_q  <= fbx_d;
            fby_q  <= fby_d;
            coll_q <= coll_d;
        end
    end

    always_ff @(posedge clk_in) begin
        ox_q     <= ox_d;
        oy_q     <= oy_d;
        clip_q   <= clip_d;
        w16_q    <= w16_d;
        nrows_q  <= nrows_d;
        nbytes_q <= nbytes_d;
        idx_q    <= idx_d;
        cur_r_q  <= cur_r_d;
        cur_c_q  <= cur_c_d;
        buf_q    <= buf_d;
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: behavioural sprite memory and 64x32 framebuffer around the DUT.
module tb_sprite_blitter;
    localparam int SW = 64;
    localparam int SH = 32;

    logic clk = 1'b0;
    logic rst_n;

    sprite_blitter_if #(.XW(6), .YW(5)) bus ();

    sprite_blitter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk_in   (clk),
        .rst_in_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [4096];
    bit          fb [SH][SW];
    bit          fb_clr;
    int          we_cnt;
    int          done_cnt;
    int          alog_n;
    logic [11:0] alog [64];
    int          n_cmp;
    int          n_bad;

    always @(posedge clk) begin
        bus.rd_memory_data <= mem[bus.rd_memory_address];
        bus.fb_rd_px       <= fb[bus.fb_y][bus.fb_x];
        if (fb_clr) begin
            foreach (fb[y, x]) fb[y][x] <= 1'b0;
        end else if (bus.fb_we) begin
            fb[bus.fb_y][bus.fb_x] <= bus.fb_wr_px;
        end
        if (bus.fb_we) we_cnt <= we_cnt + 1;
        if (bus.done)  done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.busy) begin
            alog[alog_n[5:0]] <= bus.rd_memory_address;
            alog_n            <= alog_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbrow(input int y, input int x0);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = fb[y][x0+i];
        return r;
    endfunction

    function automatic int fb_pop();
        int p = 0;
        foreach (fb[y, x]) p += int'(fb[y][x]);
        return p;
    endfunction

    task automatic fb_clear();
        @(negedge clk);
        fb_clr = 1'b1;
        @(negedge clk);
        fb_clr = 1'b0;
    endtask

    // Called right after a negedge; returns at the negedge where done is seen, lat = cycles start..done
    task automatic draw(input logic [7:0] x, input logic [7:0] y, input logic [11:0] a,
                        input logic [3:0] n, input logic w, input logic cl, input bit poke,
                        output int lat);
        bus.spr_x    = x;
        bus.spr_y    = y;
        bus.spr_addr = a;
        bus.spr_n    = n;
        bus.wide16   = w;
        bus.clip_en  = cl;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 2;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 4) begin
                bus.start  = 1'b1;
                bus.spr_x  = 8'd20;
                bus.spr_n  = 4'd0;
                bus.wide16 = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, w0, d0, a0;
        rst_n        = 1'b0;
        fb_clr       = 1'b0;
        bus.start    = 1'b0;
        bus.spr_x    = '0;
        bus.spr_y    = '0;
        bus.spr_addr = '0;
        bus.spr_n    = '0;
        bus.wide16   = 1'b0;
        bus.clip_en  = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[12'h300] = 8'hF0;
        mem[12'h310] = 8'hC0;
        mem[12'h311] = 8'hC0;
        mem[12'hFFF] = 8'h80;
        mem[12'h000] = 8'h01;
        mem[12'h01E] = 8'h01;
        mem[12'h01F] = 8'hFF;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_coll", 32'(bus.collision), 32'd0);
        chk("rst_we", 32'(bus.fb_we), 32'd0);
        chk("rst_wrpx", 32'(bus.fb_wr_px), 32'd0);
        chk("rst_fbx", 32'(bus.fb_x), 32'd0);
        chk("rst_fby", 32'(bus.fb_y), 32'd0);
        chk("rst_addr", 32'(bus.rd_memory_address), 32'd0);
        fb_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8-wide single row, blank screen
        w0 = we_cnt; d0 = done_cnt; a0 = alog_n;
        draw(8'd0, 8'd0, 12'h300, 4'd1, 1'b0, 1'b0, 1'b0, lat);
        chk("t1_lat", 32'(lat), 32'd12);
        chk("t1_coll", 32'(bus.collision), 32'd0);
        chk("t1_we", 32'(we_cnt - w0), 32'd4);
        chk("t1_row0", 32'(fbrow(0, 0)), 32'h F0);
        chk("t1_addr0", 32'(alog[a0 & 63]), 32'h300);
        @(negedge clk);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Same draw again erases and collides
        w0 = we_cnt;
        draw(8'd0, 8'd0, 12'h300, 4'd1, 1'b0, 1'b0, 1'b0, lat);
        chk("t2_lat", 32'(lat), 32'd12);
        chk("t2_coll", 32'(bus.collision), 32'd1);
        chk("t2_we", 32'(we_cnt - w0), 32'd4);
        chk("t2_row0", 32'(fbrow(0, 0)), 32'h00);
        @(negedge clk);

        // Zero rows: immediate finish, collision cleared
        w0 = we_cnt; d0 = done_cnt;
        draw(8'd5, 8'd5, 12'h300, 4'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_coll", 32'(bus.collision), 32'd0);
        chk("t3_we", 32'(we_cnt - w0), 32'd0);
        @(negedge clk);
        chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Corner wrap
        fb_clear();
        w0 = we_cnt;
        draw(8'd62, 8'd31, 12'h310, 4'd2, 1'b0, 1'b0, 1'b0, lat);
        chk("t4_lat", 32'(lat), 32'd13);
        chk("t4_we", 32'(we_cnt - w0), 32'd4);
        chk("t4_pix", 32'({fb[31][62], fb[31][63], fb[0][62], fb[0][63]}), 32'hF);
        chk("t4_pop", 32'(fb_pop()), 32'd4);
        chk("t4_coll", 32'(bus.collision), 32'd0);
        @(negedge clk);

        // Corner clip
        fb_clear();
        w0 = we_cnt;
        draw(8'd62, 8'd31, 12'h310, 4'd2, 1'b0, 1'b1, 1'b0, lat);
        chk("t5_lat", 32'(lat), 32'd9);
        chk("t5_we", 32'(we_cnt - w0), 32'd2);
        chk("t5_pix", 32'({fb[31][62], fb[31][63], fb[0][62], fb[0][63]}), 32'hC);
        chk("t5_pop", 32'(fb_pop()), 32'd2);
        @(negedge clk);

        // 16x16 sprite with address wrap at 0xFFF
        fb_clear();
        w0 = we_cnt; d0 = done_cnt; a0 = alog_n;
        draw(8'd10, 8'd5, 12'hFFF, 4'd0, 1'b1, 1'b0, 1'b0, lat);
        chk("t6_lat", 32'(lat), 32'd41);
        chk("t6_we", 32'(we_cnt - w0), 32'd3);
        chk("t6_pix", 32'({fb[5][10], fb[5][25], fb[20][25]}), 32'h7);
        chk("t6_pop", 32'(fb_pop()), 32'd3);
        chk("t6_addr0", 32'(alog[a0 & 63]), 32'hFFF);
        chk("t6_addr1", 32'(alog[(a0 + 1) & 63]), 32'h000);
        chk("t6_addr31", 32'(alog[(a0 + 31) & 63]), 32'h01E);
        @(negedge clk);
        chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Start pulsed mid-draw must be ignored
        fb_clear();
        w0 = we_cnt; d0 = done_cnt;
        draw(8'd0, 8'd0, 12'h300, 4'd1, 1'b0, 1'b0, 1'b1, lat);
        chk("t7_lat", 32'(lat), 32'd12);
        chk("t7_we", 32'(we_cnt - w0), 32'd4);
        chk("t7_row0", 32'(fbrow(0, 0)), 32'hF0);
        chk("t7_x20", 32'(fb[0][20]), 32'd0);
        repeat (2) @(negedge clk);
        chk("t7_busy_after", 32'(bus.busy), 32'd0);
        chk("t7_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset dropped during PIX_RD
        fb_clear();
        bus.spr_x    = 8'd0;
        bus.spr_y    = 8'd8;
        bus.spr_addr = 12'h300;
        bus.spr_n    = 4'd1;
        bus.wide16   = 1'b0;
        bus.clip_en  = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t8_pixrd_y", 32'(bus.fb_y), 32'd8);
        w0 = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("t8_busy", 32'(bus.busy), 32'd0);
        chk("t8_we", 32'(bus.fb_we), 32'd0);
        chk("t8_fby", 32'(bus.fb_y), 32'd0);
        chk("t8_addr", 32'(bus.rd_memory_address), 32'd0);
        repeat (4) @(negedge clk);
        chk("t8_we_cnt", 32'(we_cnt - w0), 32'd0);
        chk("t8_row8", 32'(fbrow(8, 0)), 32'h00);
        rst_n = 1'b1;
        draw(8'd0, 8'd10, 12'h300, 4'd1, 1'b0, 1'b0, 1'b0, lat);
        chk("t8_post_lat", 32'(lat), 32'd12);
        chk("t8_post_row10", 32'(fbrow(10, 0)), 32'hF0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
